// File: rtl/tt_evt_pkg.sv
// Shared types for the change-event UART transmitter: FSM states, frame header tag, event entry layout.
// Pure declarations; no timing or flow-control behaviour lives here.
package tt_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic [3:0] HDR_TAG = 4'b1010;
  localparam int         EVT_W   = 10;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] value;
  } evt_t;

  // Header byte: tag, reserved zero, overflow marker, channel.
  function automatic logic [7:0] make_hdr(input logic lost_snap, input logic [1:0] chan);
    return {HDR_TAG, 1'b0, lost_snap, chan};
  endfunction

endpackage

// File: rtl/chg_event_uart_tx_if.sv
// Event bus from the change detector: one-cycle valid pulse with channel and new value.
// No backpressure; the consumer drops events it cannot buffer.
interface chg_event_uart_tx_if;

  logic       evt_valid;
  logic [1:0] evt_chan;
  logic [7:0] evt_value;

  modport master (output evt_valid, evt_chan, evt_value);
  modport slave  (input  evt_valid, evt_chan, evt_value);

endinterface

// File: rtl/evt_fifo.sv
// Synchronous show-ahead FIFO; pop_dat is the head entry, push/pop take effect on the same edge.
// Push while full and pop while empty are ignored; full/empty derive from the registered count.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chg_event_uart_tx.sv
// Buffers detector change events and sends each as a 2-byte 8N1 frame (header, value); tx is registered,
// start bit appears two edges after the capturing edge. Events arriving with the FIFO full are dropped and flagged via lost.
module chg_event_uart_tx
  import tt_evt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  chg_event_uart_tx_if.slave   evt,
  output logic                 tx,
  output logic                 busy,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 lost
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  uart_state_t      state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       val_hold, val_hold_nxt;
  logic             byte_sel, byte_sel_nxt;
  logic             line_cur;
  logic             pop;
  logic             push;
  logic             drop;
  logic [EVT_W-1:0] push_dat;
  logic [EVT_W-1:0] pop_dat;
  evt_t             pop_evt;
  logic [CW-1:0]    fifo_count;

  assign push     = evt.evt_valid & ena & ~fifo_full;
  assign drop     = evt.evt_valid & ena & fifo_full;
  assign push_dat = {evt.evt_chan, evt.evt_value};
  assign pop_evt  = evt_t'(pop_dat);
  assign busy     = (state != ST_IDLE);

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    val_hold_nxt = val_hold;
    byte_sel_nxt = byte_sel;
    pop          = 1'b0;
    line_cur     = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (ena && !fifo_empty) begin
          pop          = 1'b1;
          shreg_nxt    = make_hdr(lost, pop_evt.chan);
          val_hold_nxt = pop_evt.value;
          byte_sel_nxt = 1'b0;
          timer_nxt    = BIT_LAST;
          state_nxt    = ST_START;
        end
      end
      ST_START: begin
        line_cur = 1'b0;
        if (timer == '0) begin
          timer_nxt   = BIT_LAST;
          bit_idx_nxt = 3'd0;
          state_nxt   = ST_DATA;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ST_DATA: begin
        line_cur = shreg[0];
        if (timer == '0) begin
          timer_nxt = BIT_LAST;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ST_STOP: begin
        // Value byte follows the header stop bit directly; ena is not consulted mid-frame.
        if (timer == '0) begin
          if (!byte_sel) begin
            shreg_nxt    = val_hold;
            byte_sel_nxt = 1'b1;
            timer_nxt    = BIT_LAST;
            state_nxt    = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      val_hold <= '0;
      byte_sel <= 1'b0;
      tx       <= 1'b1;
      lost     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      val_hold <= val_hold_nxt;
      byte_sel <= byte_sel_nxt;
      tx       <= line_cur;
      // A drop in the pop cycle must keep the overflow marker for the next header.
      if (drop) begin
        lost <= 1'b1;
      end else if (pop) begin
        lost <= 1'b0;
      end
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= DEPTH_CNT);

endmodule

// File: tb/tb_chg_event_uart_tx.sv
// Directed bench for chg_event_uart_tx with 4 clocks per bit and a 4-entry FIFO.
module tb_chg_event_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  logic ena;
  logic tx;
  logic busy;
  logic fifo_empty;
  logic fifo_full;
  logic lost;

  int checks = 0;
  int errors = 0;

  chg_event_uart_tx_if evt_if ();

  chg_event_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .evt        (evt_if.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .lost       (lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; event is captured on the next posedge, returns at the following negedge.
  task automatic send_evt(input logic [1:0] ch, input logic [7:0] v);
    evt_if.evt_valid = 1'b1;
    evt_if.evt_chan  = ch;
    evt_if.evt_value = v;
    @(negedge clk);
    evt_if.evt_valid = 1'b0;
  endtask

  // Current negedge must be the first cycle of the header start bit.
  task automatic check_frame(input logic [7:0] hdr, input logic [7:0] val, input int ena_off_at, input string name);
    logic [19:0] bits;
    bits = {1'b1, val, 1'b0, 1'b1, hdr, 1'b0};
    for (int k = 0; k < 20 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k == ena_off_at) ena = 1'b0;
      checks++;
      if (tx !== bits[k / CPB]) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, tx, bits[k / CPB]);
      end
    end
  endtask

  task automatic wait_start(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s start bit: got none within 40 cycles, expected tx=0", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s busy fall: got busy=1 after 200 cycles, expected 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    evt_if.evt_valid = 1'b0;
    evt_if.evt_chan  = 2'd0;
    evt_if.evt_value = 8'h00;
    repeat (3) @(negedge clk);
    checks += 5;
    if (tx !== 1'b1)         begin errors++; $display("FAIL rst tx: got %b expected 1", tx); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst busy: got %b expected 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst fifo_empty: got %b expected 1", fifo_empty); end
    if (fifo_full !== 1'b0)  begin errors++; $display("FAIL rst fifo_full: got %b expected 0", fifo_full); end
    if (lost !== 1'b0)       begin errors++; $display("FAIL rst lost: got %b expected 0", lost); end
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    send_evt(2'd2, 8'h5C);
    checks += 2;
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL single empty after push: got %b expected 0", fifo_empty); end
    if (tx !== 1'b1)         begin errors++; $display("FAIL single tx at N: got %b expected 1", tx); end
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b1)       begin errors++; $display("FAIL single busy at pop: got %b expected 1", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single empty at pop: got %b expected 1", fifo_empty); end
    if (tx !== 1'b1)         begin errors++; $display("FAIL single tx at N+1: got %b expected 1", tx); end
    @(negedge clk);
    check_frame(8'hA2, 8'h5C, -1, "single");
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0)       begin errors++; $display("FAIL single busy after: got %b expected 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single empty after: got %b expected 1", fifo_empty); end
    if (tx !== 1'b1)         begin errors++; $display("FAIL single idle tx: got %b expected 1", tx); end
  endtask

  task automatic test_burst();
    logic [7:0] hdrs [4] = '{8'hA4, 8'hA1, 8'hA2, 8'hA3};
    send_evt(2'd1, 8'h11);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send_evt(2'(i), 8'h20 + 8'(i));
      if (i == 3) begin
        checks += 2;
        if (fifo_full !== 1'b1) begin errors++; $display("FAIL burst full after 4: got %b expected 1", fifo_full); end
        if (lost !== 1'b0)      begin errors++; $display("FAIL burst lost before drop: got %b expected 0", lost); end
      end
    end
    checks += 2;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL burst full end: got %b expected 1", fifo_full); end
    if (lost !== 1'b1)      begin errors++; $display("FAIL burst lost: got %b expected 1", lost); end
    wait_idle("burst_first");
    for (int i = 0; i < 4; i++) begin
      wait_start("burst");
      check_frame(hdrs[i], 8'h20 + 8'(i), -1, "burst");
    end
    checks += 2;
    if (lost !== 1'b0)       begin errors++; $display("FAIL burst lost cleared: got %b expected 0", lost); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL burst drained: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_push_pop();
    logic [7:0] hdrs [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
    send_evt(2'd0, 8'h30);
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        check_frame(8'hA0, 8'h30, -1, "pp_first");
        for (int i = 0; i < 5; i++) begin
          wait_start("pp");
          check_frame(hdrs[i], 8'h31 + 8'(i), -1, "pp");
        end
      end
      begin
        @(negedge clk);
        send_evt(2'd1, 8'h31);
        send_evt(2'd2, 8'h32);
        wait_idle("pp_first");
        send_evt(2'd3, 8'h33);
        checks += 2;
        if (fifo_empty !== 1'b0) begin errors++; $display("FAIL pp empty at push+pop: got %b expected 0", fifo_empty); end
        if (fifo_full !== 1'b0)  begin errors++; $display("FAIL pp full at push+pop: got %b expected 0", fifo_full); end
        send_evt(2'd0, 8'h34);
        checks++;
        if (fifo_full !== 1'b0)  begin errors++; $display("FAIL pp count 3 full: got %b expected 0", fifo_full); end
        send_evt(2'd1, 8'h35);
        checks++;
        if (fifo_full !== 1'b1)  begin errors++; $display("FAIL pp count 4 full: got %b expected 1", fifo_full); end
      end
    join
    checks += 2;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL pp drained: got %b expected 1", fifo_empty); end
    if (lost !== 1'b0)       begin errors++; $display("FAIL pp lost: got %b expected 0", lost); end
  endtask

  task automatic test_ena();
    send_evt(2'd2, 8'h40);
    send_evt(2'd3, 8'h41);
    @(negedge clk);
    check_frame(8'hA2, 8'h40, 6, "ena_off");
    send_evt(2'd0, 8'h99);
    checks += 2;
    if (lost !== 1'b0)       begin errors++; $display("FAIL ena ignored evt lost: got %b expected 0", lost); end
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL ena fifo held: got %b expected 0", fifo_empty); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ena hold cycle %0d: got tx=%b busy=%b expected tx=1 busy=0", i, tx, busy);
      end
    end
    ena = 1'b1;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL ena resume busy: got %b expected 1", busy); end
    if (tx !== 1'b1)   begin errors++; $display("FAIL ena resume tx: got %b expected 1", tx); end
    @(negedge clk);
    check_frame(8'hA3, 8'h41, -1, "ena_resume");
    @(negedge clk);
    checks += 2;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ena ignored evt stored: got empty=%b expected 1", fifo_empty); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL ena final busy: got %b expected 0", busy); end
  endtask

  task automatic test_drop_pop();
    logic [7:0] hdrs [4] = '{8'hA5, 8'hA6, 8'hA3, 8'hA0};
    send_evt(2'd0, 8'h50);
    send_evt(2'd1, 8'h51);
    send_evt(2'd2, 8'h52);
    send_evt(2'd3, 8'h53);
    send_evt(2'd0, 8'h54);
    send_evt(2'd1, 8'h55);
    checks += 2;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL dp full: got %b expected 1", fifo_full); end
    if (lost !== 1'b1)      begin errors++; $display("FAIL dp lost set: got %b expected 1", lost); end
    wait_idle("dp_first");
    send_evt(2'd2, 8'h56);
    checks += 3;
    if (lost !== 1'b1)      begin errors++; $display("FAIL dp lost after drop+pop: got %b expected 1", lost); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL dp full after pop: got %b expected 0", fifo_full); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL dp busy: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      wait_start("dp");
      check_frame(hdrs[i], 8'h51 + 8'(i), -1, "dp");
    end
    checks += 2;
    if (lost !== 1'b0)       begin errors++; $display("FAIL dp lost final: got %b expected 0", lost); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL dp drained: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_reset_mid();
    send_evt(2'd1, 8'h60);
    send_evt(2'd2, 8'h61);
    send_evt(2'd3, 8'h62);
    send_evt(2'd0, 8'h63);
    send_evt(2'd1, 8'h64);
    send_evt(2'd2, 8'h65);
    checks += 4;
    if (tx !== 1'b0)        begin errors++; $display("FAIL mid pre tx: got %b expected 0", tx); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL mid pre busy: got %b expected 1", busy); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL mid pre full: got %b expected 1", fifo_full); end
    if (lost !== 1'b1)      begin errors++; $display("FAIL mid pre lost: got %b expected 1", lost); end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (tx !== 1'b1)         begin errors++; $display("FAIL mid rst tx: got %b expected 1", tx); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL mid rst busy: got %b expected 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid rst empty: got %b expected 1", fifo_empty); end
    if (fifo_full !== 1'b0)  begin errors++; $display("FAIL mid rst full: got %b expected 0", fifo_full); end
    if (lost !== 1'b0)       begin errors++; $display("FAIL mid rst lost: got %b expected 0", lost); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks += 3;
    if (tx !== 1'b1)         begin errors++; $display("FAIL mid post tx: got %b expected 1", tx); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL mid post busy: got %b expected 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid post empty: got %b expected 1", fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_push_pop();
    test_ena();
    test_drop_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
